// File: rtl/can_frame_player.sv
// can_frame_player: plays a stored CAN frame MSB-first onto a serial bit line
// with run-time bit timing, optional stuff-bit insertion over a leading region,
// frame replay separated by a recessive gap, and immediate abort.
module can_frame_player #(
    parameter int MAX_FRAME_LEN = 512,
    parameter int LEN_W         = 10,
    parameter int TQ_W          = 8,
    parameter int GAP_BITS      = 11,
    parameter int RPT_W         = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [MAX_FRAME_LEN-1:0] frame_bits,
    input  logic [LEN_W-1:0]         frame_len,
    input  logic                     stuff_en,
    input  logic [LEN_W-1:0]         stuff_len,
    input  logic [TQ_W-1:0]          clocks_per_bit,
    input  logic [TQ_W-1:0]          sample_offset,
    input  logic [RPT_W-1:0]         repeat_count,
    output logic                     rx_bit,
    output logic                     sample_point,
    output logic                     stuff_flag,
    output logic                     busy,
    output logic                     done,
    output logic [LEN_W-1:0]         bits_left
);

    localparam int IDX_W = (MAX_FRAME_LEN > 1) ? $clog2(MAX_FRAME_LEN) : 1;
    localparam int GAP_W = $clog2(GAP_BITS + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BITS - 1);
    localparam logic [TQ_W-1:0]  CPB_MIN  = TQ_W'(2);
    localparam logic [LEN_W-1:0] LEN_LIM  = LEN_W'(MAX_FRAME_LEN);

    typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

    state_t                   state, state_nxt;
    logic [TQ_W-1:0]          tq, tq_nxt, cpb_r, cpb_nxt, so_r, so_nxt;
    logic [MAX_FRAME_LEN-1:0] frame_r, frame_nxt;
    logic [LEN_W-1:0]         len_r, len_nxt, sl_r, sl_nxt;
    logic [LEN_W-1:0]         sent_cnt, sent_nxt, bits_left_nxt;
    logic                     se_r, se_nxt;
    logic [RPT_W-1:0]         rpt_r, rpt_nxt, rpt_cnt, rpt_cnt_nxt;
    logic [2:0]               run_len, run_len_nxt;
    logic                     run_val, run_val_nxt;
    logic [GAP_W-1:0]         gap_cnt, gap_nxt;
    logic                     rx_nxt, stuff_flag_nxt, done_nxt;

    logic                     bit_start, end_of_bit, next_bit;
    logic [MAX_FRAME_LEN-1:0] cur_frame;
    logic [LEN_W-1:0]         cur_bl, cur_sent, cur_sl, bit_idx;
    logic [2:0]               cur_run_len;
    logic                     cur_run_val, cur_se;

    logic [TQ_W-1:0]          cpb_c, so_c;
    logic [LEN_W-1:0]         sl_c;

    assign cpb_c = (clocks_per_bit < CPB_MIN) ? CPB_MIN : clocks_per_bit;
    assign so_c  = (sample_offset >= cpb_c) ? (cpb_c - 1'b1) : sample_offset;
    assign sl_c  = (stuff_len > frame_len) ? frame_len : stuff_len;

    assign busy         = (state != IDLE);
    assign sample_point = (state != IDLE) && (tq == so_r);

    // Next-state logic: bit-time counting, the per-bit decision (stuff, data
    // or end of frame) and gap/replay sequencing. The first bit of a frame is
    // decided on the same edge that accepts start or ends the previous gap,
    // using the freshly loaded frame context held in the cur_* selects.
    always_comb begin
        state_nxt      = state;
        tq_nxt         = tq;
        cpb_nxt        = cpb_r;
        so_nxt         = so_r;
        frame_nxt      = frame_r;
        len_nxt        = len_r;
        sl_nxt         = sl_r;
        se_nxt         = se_r;
        rpt_nxt        = rpt_r;
        rpt_cnt_nxt    = rpt_cnt;
        sent_nxt       = sent_cnt;
        bits_left_nxt  = bits_left;
        run_len_nxt    = run_len;
        run_val_nxt    = run_val;
        gap_nxt        = gap_cnt;
        rx_nxt         = rx_bit;
        stuff_flag_nxt = stuff_flag;
        done_nxt       = 1'b0;
        bit_start      = 1'b0;
        cur_frame      = frame_r;
        cur_bl         = bits_left;
        cur_sent       = sent_cnt;
        cur_sl         = sl_r;
        cur_se         = se_r;
        cur_run_len    = run_len;
        cur_run_val    = run_val;
        bit_idx        = '0;
        next_bit       = 1'b1;
        end_of_bit     = (tq == (cpb_r - 1'b1));

        if (abort) begin
            state_nxt      = IDLE;
            tq_nxt         = '0;
            rx_nxt         = 1'b1;
            stuff_flag_nxt = 1'b0;
            bits_left_nxt  = '0;
            sent_nxt       = '0;
            run_len_nxt    = '0;
            gap_nxt        = '0;
            rpt_cnt_nxt    = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        frame_nxt   = frame_bits;
                        len_nxt     = frame_len;
                        se_nxt      = stuff_en;
                        sl_nxt      = sl_c;
                        cpb_nxt     = cpb_c;
                        so_nxt      = so_c;
                        rpt_nxt     = repeat_count;
                        rpt_cnt_nxt = '0;
                        cur_frame   = frame_bits;
                        cur_bl      = frame_len;
                        cur_sent    = '0;
                        cur_sl      = sl_c;
                        cur_se      = stuff_en;
                        cur_run_len = '0;
                        cur_run_val = 1'b1;
                        bit_start   = 1'b1;
                    end
                end
                FRAME: begin
                    if (end_of_bit) begin
                        bit_start = 1'b1;
                    end else begin
                        tq_nxt = tq + 1'b1;
                    end
                end
                GAP: begin
                    if (end_of_bit) begin
                        tq_nxt = '0;
                        if (gap_cnt == GAP_LAST) begin
                            gap_nxt = '0;
                            if (rpt_cnt < rpt_r) begin
                                rpt_cnt_nxt = rpt_cnt + 1'b1;
                                cur_bl      = len_r;
                                cur_sent    = '0;
                                cur_run_len = '0;
                                cur_run_val = 1'b1;
                                bit_start   = 1'b1;
                            end else begin
                                state_nxt = IDLE;
                                done_nxt  = 1'b1;
                            end
                        end else begin
                            gap_nxt = gap_cnt + 1'b1;
                        end
                    end else begin
                        tq_nxt = tq + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase

            if (bit_start) begin
                tq_nxt   = '0;
                bit_idx  = cur_bl - 1'b1;
                next_bit = (bit_idx < LEN_LIM) ? cur_frame[bit_idx[IDX_W-1:0]] : 1'b1;
                if (cur_se && (cur_sent <= cur_sl) && (cur_run_len == 3'd5)) begin
                    state_nxt      = FRAME;
                    rx_nxt         = ~cur_run_val;
                    stuff_flag_nxt = 1'b1;
                    run_len_nxt    = 3'd1;
                    run_val_nxt    = ~cur_run_val;
                    bits_left_nxt  = cur_bl;
                    sent_nxt       = cur_sent;
                end else if (cur_bl == '0) begin
                    state_nxt      = GAP;
                    rx_nxt         = 1'b1;
                    stuff_flag_nxt = 1'b0;
                    bits_left_nxt  = '0;
                    gap_nxt        = '0;
                end else begin
                    state_nxt      = FRAME;
                    rx_nxt         = next_bit;
                    stuff_flag_nxt = 1'b0;
                    bits_left_nxt  = bit_idx;
                    sent_nxt       = cur_sent + 1'b1;
                    run_val_nxt    = next_bit;
                    if ((cur_run_len != 3'd0) && (next_bit == cur_run_val)) begin
                        run_len_nxt = (cur_run_len == 3'd7) ? 3'd7 : (cur_run_len + 1'b1);
                    end else begin
                        run_len_nxt = 3'd1;
                    end
                end
            end
        end
    end

    // State and datapath registers; the line idles recessive out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tq         <= '0;
            cpb_r      <= '0;
            so_r       <= '0;
            frame_r    <= '0;
            len_r      <= '0;
            sl_r       <= '0;
            se_r       <= 1'b0;
            rpt_r      <= '0;
            rpt_cnt    <= '0;
            sent_cnt   <= '0;
            bits_left  <= '0;
            run_len    <= '0;
            run_val    <= 1'b1;
            gap_cnt    <= '0;
            rx_bit     <= 1'b1;
            stuff_flag <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            tq         <= tq_nxt;
            cpb_r      <= cpb_nxt;
            so_r       <= so_nxt;
            frame_r    <= frame_nxt;
            len_r      <= len_nxt;
            sl_r       <= sl_nxt;
            se_r       <= se_nxt;
            rpt_r      <= rpt_nxt;
            rpt_cnt    <= rpt_cnt_nxt;
            sent_cnt   <= sent_nxt;
            bits_left  <= bits_left_nxt;
            run_len    <= run_len_nxt;
            run_val    <= run_val_nxt;
            gap_cnt    <= gap_nxt;
            rx_bit     <= rx_nxt;
            stuff_flag <= stuff_flag_nxt;
            done       <= done_nxt;
        end
    end

endmodule
